// File: rtl/watch_pkg.sv
// Shared types and constants for the watch time-setting path.
// Rev 1.0 - initial release.
`default_nettype none

package watch_pkg;

  typedef enum logic [1:0] {
    S_TENS = 2'd0,
    S_ONES = 2'd1,
    S_OUT  = 2'd2
  } entry_state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_DIGIT   = 2'b01;
  localparam logic [1:0] ERR_RANGE   = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;

endpackage

`default_nettype wire

// File: rtl/bcd_entry_to_binary_if.sv
// Digit-entry handshake and result bundle for bcd_entry_to_binary.
// Rev 1.0 - initial release.
`default_nettype none

interface bcd_entry_to_binary_if;
  logic       digit_valid;
  logic [3:0] digit;
  logic       digit_ready;
  logic [7:0] value;
  logic       value_valid;
  logic       err;
  logic [1:0] err_code;
  logic       busy;

  modport master (
    output digit_valid, digit,
    input  digit_ready, value, value_valid, err, err_code, busy
  );

  modport slave (
    input  digit_valid, digit,
    output digit_ready, value, value_valid, err, err_code, busy
  );
endinterface

`default_nettype wire

// File: rtl/bcd_pair_to_bin.sv
// Combinational two-digit BCD to binary: bin = tens*10 + ones (max 99, no overflow).
// Rev 1.0 - initial release.
`default_nettype none

module bcd_pair_to_bin (
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  output logic [7:0] bin
);

  logic [7:0] tens_w;
  assign tens_w = {4'b0000, tens};
  assign bin    = (tens_w << 3) + (tens_w << 1) + {4'b0000, ones};

endmodule

`default_nettype wire

// File: rtl/bcd_entry_to_binary.sv
// Serial two-digit BCD entry with range check; optional S_ONES timeout under BCD_ENTRY_TIMEOUT_EN.
// Rev 1.0 - initial release.
`default_nettype none

module bcd_entry_to_binary
  import watch_pkg::*;
#(
  parameter int MAX_VAL     = 59,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  bcd_entry_to_binary_if.slave  bus
);

  localparam logic [7:0] MAX_VAL_B = 8'(MAX_VAL);

  entry_state_t state;
  logic [3:0]   tens;
  logic [7:0]   sum;
  logic [7:0]   value_r;
  logic         value_valid_r;
  logic         err_r;
  logic [1:0]   err_code_r;
  logic         digit_bad;

`ifdef BCD_ENTRY_TIMEOUT_EN
  localparam int         CNT_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);
  logic [CNT_W-1:0] tmo_cnt;
`endif

  bcd_pair_to_bin u_pair (
    .tens (tens),
    .ones (bus.digit),
    .bin  (sum)
  );

  assign digit_bad = (bus.digit > BCD_DIGIT_MAX);

  // Ready is a pure state decode so upstream sees no input-to-output path.
  assign bus.digit_ready = (state != S_OUT);
  assign bus.busy        = (state == S_ONES);
  assign bus.value       = value_r;
  assign bus.value_valid = value_valid_r;
  assign bus.err         = err_r;
  assign bus.err_code    = err_code_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_TENS;
      tens          <= 4'd0;
      value_r       <= 8'd0;
      value_valid_r <= 1'b0;
      err_r         <= 1'b0;
      err_code_r    <= ERR_NONE;
`ifdef BCD_ENTRY_TIMEOUT_EN
      tmo_cnt       <= '0;
`endif
    end else begin
      value_valid_r <= 1'b0;
      err_r         <= 1'b0;
      err_code_r    <= ERR_NONE;
      case (state)
        S_TENS: begin
          if (bus.digit_valid) begin
            if (digit_bad) begin
              err_r      <= 1'b1;
              err_code_r <= ERR_DIGIT;
            end else begin
              tens  <= bus.digit;
              state <= S_ONES;
`ifdef BCD_ENTRY_TIMEOUT_EN
              tmo_cnt <= '0;
`endif
            end
          end
        end
        S_ONES: begin
          // A transfer on the terminal-count cycle takes priority over timeout.
          if (bus.digit_valid) begin
            if (digit_bad) begin
              err_r      <= 1'b1;
              err_code_r <= ERR_DIGIT;
              state      <= S_TENS;
            end else if (sum > MAX_VAL_B) begin
              err_r      <= 1'b1;
              err_code_r <= ERR_RANGE;
              state      <= S_TENS;
            end else begin
              value_r       <= sum;
              value_valid_r <= 1'b1;
              state         <= S_OUT;
            end
          end
`ifdef BCD_ENTRY_TIMEOUT_EN
          else if (tmo_cnt == TMO_LAST) begin
            err_r      <= 1'b1;
            err_code_r <= ERR_TIMEOUT;
            state      <= S_TENS;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        S_OUT: begin
          state <= S_TENS;
        end
        default: begin
          state <= S_TENS;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
